// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single 32-bit ALU, with an optional
// per-port lock (released by the owner or by an idle timeout) and one issue stage.
module alu_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_lock,
    input  logic [2:0]  req0_sel,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_lock,
    input  logic [2:0]  req1_sel,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_neg
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED0  = 2'd1,
        ST_LOCKED1  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state, state_nx;
    logic             last_grant, last_grant_nx;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;

    logic grant0, grant1;
    logic xfer0, xfer1, xfer, xfer_id, xfer_lock;

    logic        stage_valid;
    logic        stage_id;
    logic [2:0]  stage_sel;
    logic [31:0] stage_a, stage_b;
    logic [31:0] alu_out;

    // Handshake: a transfer on port i happens at a rising edge where reqi_valid and
    // reqi_ready are both high; ready depends on valid but valid never on ready.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (req0_valid && req1_valid) begin
                    grant0 = last_grant;
                    grant1 = ~last_grant;
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end
            end
            ST_LOCKED0: grant0 = 1'b1;
            ST_LOCKED1: grant1 = 1'b1;
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
    end

    assign req0_ready = req0_valid & grant0 & ~rst;
    assign req1_ready = req1_valid & grant1 & ~rst;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign xfer       = xfer0 | xfer1;
    assign xfer_id    = xfer1;
    assign xfer_lock  = xfer1 ? req1_lock : req0_lock;

    // An owner transfer takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        idle_cnt_nx   = idle_cnt;
        if (xfer) begin
            last_grant_nx = xfer_id;
            idle_cnt_nx   = '0;
            if (!xfer_lock)
                state_nx = ST_UNLOCKED;
            else if (xfer_id)
                state_nx = ST_LOCKED1;
            else
                state_nx = ST_LOCKED0;
        end else if (state != ST_UNLOCKED) begin
            if (idle_cnt == IDLE_LAST) begin
                state_nx      = ST_UNLOCKED;
                idle_cnt_nx   = '0;
                last_grant_nx = (state == ST_LOCKED1);
            end else begin
                idle_cnt_nx = idle_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_UNLOCKED;
            last_grant  <= 1'b1;
            idle_cnt    <= '0;
            stage_valid <= 1'b0;
            stage_id    <= 1'b0;
            stage_sel   <= 3'd0;
            stage_a     <= 32'd0;
            stage_b     <= 32'd0;
        end else begin
            state       <= state_nx;
            last_grant  <= last_grant_nx;
            idle_cnt    <= idle_cnt_nx;
            stage_valid <= xfer;
            if (xfer) begin
                stage_id  <= xfer_id;
                stage_sel <= xfer_id ? req1_sel : req0_sel;
                stage_a   <= xfer_id ? req1_a : req0_a;
                stage_b   <= xfer_id ? req1_b : req0_b;
            end
        end
    end

    always_comb begin
        alu_out = stage_b;
        case (stage_sel)
            3'b000:  alu_out = stage_a + stage_b;
            3'b001:  alu_out = stage_a - stage_b;
            3'b010:  alu_out = stage_a & stage_b;
            3'b011:  alu_out = stage_a | stage_b;
            3'b101:  alu_out = {31'd0, stage_a < stage_b};
            3'b110:  alu_out = stage_a ^ stage_b;
            default: alu_out = stage_b;
        endcase
    end

    assign rsp_valid  = stage_valid;
    assign rsp_id     = stage_id;
    assign rsp_result = alu_out;
    assign rsp_zero   = (alu_out == 32'd0);
    assign rsp_neg    = alu_out[31];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus hand-written lock/timeout/reset sequences,
// with an expected-response queue checked one cycle after each accepted request.
module tb_alu_arbiter;

    localparam int W = 35;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_lock, req0_ready;
    logic [2:0]  req0_sel;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_lock, req1_ready;
    logic [2:0]  req1_sel;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_neg;
    logic [31:0] rsp_result;

    typedef struct {
        logic        v0, l0;
        logic [2:0]  s0;
        logic [31:0] a0, b0;
        logic        v1, l1;
        logic [2:0]  s1;
        logic [31:0] a1, b1;
        logic        r0, r1;
    } vec_t;

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs[16];

    alu_arbiter #(.LOCK_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic id, input logic [2:0] sel,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (sel)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = (a < b) ? 32'd1 : 32'd0;
            3'b110:  r = a ^ b;
            default: r = b;
        endcase
        return {id, r, (r == 32'd0), r[31]};
    endfunction

    function automatic vec_t mk(input logic v0, input logic l0, input logic [2:0] s0,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic l1, input logic [2:0] s1,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.s0 = s0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.l1 = l1; v.s1 = s1; v.a1 = a1; v.b1 = b1;
        v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check last cycle's response and this cycle's readies, push.
    task automatic step(input string name, input logic r, input vec_t v);
        logic [W-1:0] e;
        rst = r;
        req0_valid = v.v0; req0_lock = v.l0; req0_sel = v.s0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_lock = v.l1; req1_sel = v.s1; req1_a = v.a1; req1_b = v.b1;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, " rsp_valid"}, rsp_valid, 1);
            chk({name, " rsp id/result/zero/neg"}, {rsp_id, rsp_result, rsp_zero, rsp_neg}, e);
        end else begin
            chk({name, " rsp_valid idle"}, rsp_valid, 0);
        end
        chk({name, " req0_ready"}, req0_ready, v.r0 & ~r);
        chk({name, " req1_ready"}, req1_ready, v.r1 & ~r);
        if (!r && v.r0)
            exp_q.push_back(model(1'b0, v.s0, v.a0, v.b0));
        else if (!r && v.r1)
            exp_q.push_back(model(1'b1, v.s1, v.a1, v.b1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1,0,3'b000,32'd5,32'd7,         1,0,3'b001,32'd3,32'd3,          1,0);
        vecs[1]  = mk(1,0,3'b000,32'd5,32'd7,         1,0,3'b001,32'd3,32'd3,          0,1);
        vecs[2]  = mk(1,0,3'b010,32'hF0F0_F0F0,32'h0FF0_0FF0, 1,0,3'b011,32'h1,32'h2,   1,0);
        vecs[3]  = mk(1,0,3'b010,32'hF0F0_F0F0,32'h0FF0_0FF0, 1,0,3'b011,32'h1,32'h2,   0,1);
        vecs[4]  = mk(1,0,3'b000,32'd5,32'd7,         0,0,3'b000,32'd0,32'd0,          1,0);
        vecs[5]  = mk(0,0,3'b000,32'd0,32'd0,         1,0,3'b001,32'd3,32'd3,          0,1);
        vecs[6]  = mk(0,0,3'b000,32'd0,32'd0,         1,0,3'b001,32'd3,32'd4,          0,1);
        vecs[7]  = mk(0,0,3'b000,32'd0,32'd0,         1,0,3'b101,32'd1,32'hFFFF_FFFF,  0,1);
        vecs[8]  = mk(1,0,3'b010,32'h1234_5678,32'h0000_FFFF, 0,0,3'b000,32'd0,32'd0,   1,0);
        vecs[9]  = mk(0,0,3'b000,32'd0,32'd0,         1,0,3'b011,32'h8000_0000,32'h1,  0,1);
        vecs[10] = mk(1,0,3'b110,32'hAAAA_5555,32'hAAAA_5555, 0,0,3'b000,32'd0,32'd0,   1,0);
        vecs[11] = mk(0,0,3'b000,32'd0,32'd0,         1,0,3'b111,32'd9,32'hDEAD_BEEF,  0,1);
        vecs[12] = mk(1,0,3'b100,32'd9,32'h0000_0042, 0,0,3'b000,32'd0,32'd0,          1,0);
        vecs[13] = mk(0,0,3'b000,32'd0,32'd0,         0,0,3'b000,32'd0,32'd0,          0,0);
        vecs[14] = mk(0,0,3'b000,32'd0,32'd0,         1,0,3'b101,32'd5,32'd3,          0,1);
        vecs[15] = mk(1,0,3'b000,32'hFFFF_FFFF,32'd1, 1,0,3'b001,32'd0,32'd1,          1,0);

        rst = 1'b1;
        req0_valid = 0; req0_lock = 0; req0_sel = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_lock = 0; req1_sel = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset rsp_zero", rsp_zero, 1);
        chk("reset rsp_neg", rsp_neg, 0);
        step("reset hold", 1, mk(1,0,3'b000,32'd5,32'd7, 1,0,3'b000,32'd1,32'd2, 0,0));

        for (int i = 0; i < 16; i++)
            step($sformatf("vec%0d", i), 0, vecs[i]);

        // Port 0 lock expires after 16 idle cycles; port 1 then served.
        step("lock0 take", 0, mk(1,1,3'b000,$urandom,$urandom, 0,0,3'b000,0,0, 1,0));
        for (int k = 0; k < 16; k++)
            step($sformatf("lock0 hold%0d", k), 0,
                 mk(0,0,3'b000,0,0, 1,0,3'b000,$urandom_range(1000,0),$urandom_range(1000,0), 0,0));
        step("lock0 timeout", 0, mk(0,0,3'b000,0,0, 1,0,3'b110,$urandom,$urandom, 0,1));

        // Port 1 lock expires; the following tie goes to port 0.
        step("lock1 take", 0, mk(0,0,3'b000,0,0, 1,1,3'b001,$urandom,$urandom, 0,1));
        for (int k = 0; k < 16; k++)
            step($sformatf("lock1 hold%0d", k), 0, mk(1,0,3'b000,$urandom,$urandom, 0,0,3'b000,0,0, 0,0));
        step("lock1 timeout tie", 0, mk(1,0,3'b011,$urandom,$urandom, 1,0,3'b000,$urandom,$urandom, 1,0));

        // Owner transfer in the timeout cycle keeps the lock.
        step("relock take", 0, mk(1,1,3'b000,32'd10,32'd20, 0,0,3'b000,0,0, 1,0));
        for (int k = 0; k < 15; k++)
            step($sformatf("relock hold%0d", k), 0, mk(0,0,3'b000,0,0, 1,0,3'b000,32'd1,32'd1, 0,0));
        step("relock at timeout", 0, mk(1,1,3'b001,32'd7,32'd9, 1,0,3'b000,32'd1,32'd1, 1,0));
        step("relock still held", 0, mk(0,0,3'b000,0,0, 1,0,3'b000,32'd1,32'd1, 0,0));
        step("unlock xfer", 0, mk(1,0,3'b101,32'd2,32'd3, 1,0,3'b000,32'd4,32'd5, 1,0));
        step("after unlock", 0, mk(1,0,3'b000,32'd6,32'd6, 1,0,3'b010,32'hFF,32'h0F, 0,1));

        // Reset mid-stream with both ports valid.
        step("pre-reset", 0, mk(1,0,3'b000,32'd100,32'd1, 1,0,3'b000,32'd2,32'd2, 1,0));
        step("mid reset 1", 1, mk(1,0,3'b000,32'd1,32'd1, 1,0,3'b000,32'd2,32'd2, 0,0));
        step("mid reset 2", 1, mk(1,0,3'b000,32'd1,32'd1, 1,0,3'b000,32'd2,32'd2, 0,0));
        step("post-reset tie", 0, mk(1,0,3'b001,32'd1,32'd1, 1,0,3'b000,32'd2,32'd2, 1,0));
        step("drain", 0, mk(0,0,3'b000,0,0, 0,0,3'b000,0,0, 0,0));
        step("drain idle", 0, mk(0,0,3'b000,0,0, 0,0,3'b000,0,0, 0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
